// File: rtl/hex_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a one-entry pending register committed at frame end.
// Latency: outputs lag cnt/idx by 1 cycle; a loaded value is visible 2..4*REFRESH_DIV+1 cycles after acceptance.
// Backpressure: load_ready drops while a value is pending and rises the cycle after it commits.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   load_valid/ready    handshake for load_data (16 bits, nibble k -> digit k) and load_blank
//   seg_n               registered active-low segments {g,f,e,d,c,b,a}
//   dig_en_n            registered active-low digit enables, bit k -> digit k
module hex_scan_ctrl #(
   parameter int REFRESH_DIV = 50000,
   parameter int GUARD       = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [15:0] load_data,
   input  logic        load_blank,
   output logic [6:0]  seg_n,
   output logic [3:0]  dig_en_n
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [15:0]   disp;
   logic          disp_blank;
   logic [15:0]   pend;
   logic          pend_blank;
   logic          pend_valid;

   logic          cnt_wrap;
   logic          frame_end;
   logic          xfer;
   logic          commit;
   logic          in_guard;
   logic          digit_blank;
   logic [3:0]    nib;
   logic [6:0]    seg_next;
   logic [3:0]    dig_next;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign load_ready = ~pend_valid;
   assign cnt_wrap   = (cnt == CNT_MAX);
   assign frame_end  = cnt_wrap && (idx == 2'd3);
   assign xfer       = load_valid && load_ready;
   // xfer needs an empty pending slot and commit needs a full one, so they never collide.
   assign commit     = frame_end && pend_valid;

   // A zero guard would make the compare constant; tie it off explicitly instead.
   generate
      if (GUARD == 0) begin : g_no_guard
         assign in_guard = 1'b0;
      end else begin : g_guard
         assign in_guard = (cnt < CW'(GUARD));
      end
   endgenerate

   // Leading-zero blanking: digit k >= 1 goes dark when it and every higher nibble is zero.
   always_comb begin
      nib         = disp[3:0];
      digit_blank = 1'b0;
      case (idx)
         2'd0: begin
            nib         = disp[3:0];
            digit_blank = 1'b0;
         end
         2'd1: begin
            nib         = disp[7:4];
            digit_blank = disp_blank && (disp[15:4] == 12'h000);
         end
         2'd2: begin
            nib         = disp[11:8];
            digit_blank = disp_blank && (disp[15:8] == 8'h00);
         end
         default: begin
            nib         = disp[15:12];
            digit_blank = disp_blank && (disp[15:12] == 4'h0);
         end
      endcase

      seg_next = digit_blank ? 7'h7F : seg_decode(nib);
      dig_next = ~(4'b0001 << idx);
      if (in_guard) begin
         seg_next = 7'h7F;
         dig_next = 4'hF;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         idx        <= 2'd0;
         disp       <= 16'h0000;
         disp_blank <= 1'b1;
         pend       <= 16'h0000;
         pend_blank <= 1'b0;
         pend_valid <= 1'b0;
         seg_n      <= 7'h7F;
         dig_en_n   <= 4'hF;
      end else begin
         cnt <= cnt_wrap ? '0 : cnt + 1'b1;
         if (cnt_wrap) begin
            idx <= idx + 2'd1;
         end
         if (commit) begin
            disp       <= pend;
            disp_blank <= pend_blank;
            pend_valid <= 1'b0;
         end else if (xfer) begin
            pend       <= load_data;
            pend_blank <= load_blank;
            pend_valid <= 1'b1;
         end
         seg_n    <= seg_next;
         dig_en_n <= dig_next;
      end
   end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
module tb_hex_scan_ctrl;

   localparam int DIV   = 4;
   localparam int FRAME = 4 * DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_valid = 1'b0;
   logic [15:0] load_data = 16'h0000;
   logic        load_blank = 1'b0;
   logic        load_ready, load_ready0;
   logic [6:0]  seg_n, seg_n0;
   logic [3:0]  dig_en_n, dig_en_n0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hex_scan_ctrl #(.REFRESH_DIV(DIV), .GUARD(1)) u_dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .load_blank(load_blank), .seg_n(seg_n), .dig_en_n(dig_en_n));

   hex_scan_ctrl #(.REFRESH_DIV(DIV), .GUARD(0)) u_dut0 (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready0),
      .load_data(load_data), .load_blank(load_blank), .seg_n(seg_n0), .dig_en_n(dig_en_n0));

   // Reference model: position is a plain cycle count since reset; commits are scheduled
   // at the first frame-end cycle strictly after the accepting cycle.
   logic [6:0]  seg_tab [16];
   int          m_t = 0;
   logic [15:0] m_disp = 16'h0000;
   logic        m_blank = 1'b1;
   logic [15:0] m_pend = 16'h0000;
   logic        m_pend_blank = 1'b0;
   logic        m_pv = 1'b0;
   int          m_commit_at = 0;
   logic [6:0]  e_seg [2];
   logic [3:0]  e_dig [2];
   bit          m_live = 1'b0;
   bit          m_started = 1'b0;

   initial begin
      seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
      seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
      seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
      seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
   end

   function automatic logic [10:0] exp_out(input int t, input int guard,
                                           input logic [15:0] d, input logic b);
      int         phase;
      int         k;
      logic [15:0] upper;
      logic [6:0] s;
      logic [3:0] dg;
      phase = t % DIV;
      k     = (t / DIV) % 4;
      if (phase < guard) return {7'h7F, 4'hF};
      upper = d >> (4 * k);
      s     = seg_tab[upper[3:0]];
      if (k >= 1 && b && upper == 16'h0000) s = 7'h7F;
      dg = ~(4'b0001 << k);
      return {s, dg};
   endfunction

   initial begin
      logic [10:0] o0, o1;
      logic        rdy;
      int          c;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_t = 0; m_disp = 16'h0000; m_blank = 1'b1; m_pv = 1'b0;
            e_seg[0] = 7'h7F; e_dig[0] = 4'hF;
            e_seg[1] = 7'h7F; e_dig[1] = 4'hF;
            m_started = 1'b0;
         end else begin
            o0 = exp_out(m_t, 1, m_disp, m_blank);
            o1 = exp_out(m_t, 0, m_disp, m_blank);
            e_seg[0] = o0[10:4]; e_dig[0] = o0[3:0];
            e_seg[1] = o1[10:4]; e_dig[1] = o1[3:0];
            rdy = !m_pv;
            if (m_pv && m_t == m_commit_at) begin
               m_disp = m_pend; m_blank = m_pend_blank; m_pv = 1'b0;
            end
            if (load_valid && rdy) begin
               m_pend = load_data; m_pend_blank = load_blank; m_pv = 1'b1;
               c = (m_t / FRAME) * FRAME + FRAME - 1;
               if (c <= m_t) c = c + FRAME;
               m_commit_at = c;
            end
            m_t = m_t + 1;
            m_started = 1'b1;
         end
         m_live = 1'b1;
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Continuous comparison of both instances against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (m_live) begin
            chk("seg_g1", 16'(seg_n), 16'(e_seg[0]));
            chk("dig_g1", 16'(dig_en_n), 16'(e_dig[0]));
            chk("seg_g0", 16'(seg_n0), 16'(e_seg[1]));
            chk("dig_g0", 16'(dig_en_n0), 16'(e_dig[1]));
            chk("ready_g1", 16'(load_ready), 16'(!m_pv));
            chk("ready_g0", 16'(load_ready0), 16'(!m_pv));
            chk("onehot_g1", 16'($countones(~dig_en_n) <= 1), 16'd1);
            chk("onehot_g0", 16'($countones(~dig_en_n0) <= 1), 16'd1);
            if (m_started) chk("no_alloff_g0", 16'(dig_en_n0 != 4'hF), 16'd1);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_digit(input int k, output logic [6:0] s);
      int         n;
      logic [3:0] want;
      n    = 0;
      want = ~(4'b0001 << k);
      while (dig_en_n !== want && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         checks++; errors++;
         $display("FAIL wait_digit%0d timeout actual=%h required=%h", k, dig_en_n, want);
      end
      s = seg_n;
   endtask

   task automatic wait_pos(input int modv, input int target, input int limit);
      int n;
      n = 0;
      while (!((m_t % modv) == target && !m_pv) && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (n >= limit) begin
         checks++; errors++;
         $display("FAIL wait_pos timeout actual=%0d required=%0d", m_t % modv, target);
      end
   endtask

   task automatic do_load(input logic [15:0] d, input logic b);
      int n;
      n = 0;
      while (!load_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) begin
         checks++; errors++;
         $display("FAIL load_wait timeout actual=%b required=1", load_ready);
      end
      load_valid = 1'b1; load_data = d; load_blank = b;
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   task automatic show(input string name, input logic [15:0] d, input logic b,
                       input logic [6:0] x0, input logic [6:0] x1,
                       input logic [6:0] x2, input logic [6:0] x3);
      logic [6:0] s;
      do_load(d, b);
      tick(18);
      wait_digit(0, s); chk({name, "_d0"}, 16'(s), 16'(x0));
      wait_digit(1, s); chk({name, "_d1"}, 16'(s), 16'(x1));
      wait_digit(2, s); chk({name, "_d2"}, 16'(s), 16'(x2));
      wait_digit(3, s); chk({name, "_d3"}, 16'(s), 16'(x3));
   endtask

   initial begin
      logic [6:0] s;
      int         n;

      // Reset and first slots
      tick(3);
      rst = 1'b0;
      chk("rst_ready", 16'(load_ready), 16'd1);
      chk("rst_seg", 16'(seg_n), 16'h7F);
      chk("rst_dig", 16'(dig_en_n), 16'hF);
      tick(1);
      chk("guard0_dig", 16'(dig_en_n), 16'hF);
      tick(1);
      chk("d0_dig", 16'(dig_en_n), 16'hE);
      chk("d0_seg", 16'(seg_n), 16'h40);
      wait_digit(1, s); chk("rst_d1", 16'(s), 16'h7F);
      wait_digit(2, s); chk("rst_d2", 16'(s), 16'h7F);
      wait_digit(3, s); chk("rst_d3", 16'(s), 16'h7F);

      // Mid-frame load, second request held until ready returns
      wait_pos(FRAME, 5, 40);
      load_valid = 1'b1; load_data = 16'h1A3F; load_blank = 1'b0;
      @(negedge clk);
      load_data = 16'h2222;
      chk("ready_low", 16'(load_ready), 16'd0);
      n = 0;
      while (!load_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 16'(n), 16'd10);
      @(negedge clk);
      load_valid = 1'b0;
      chk("held_accepted", 16'(load_ready), 16'd0);
      wait_digit(0, s); chk("1a3f_d0", 16'(s), 16'h0E);
      wait_digit(1, s); chk("1a3f_d1", 16'(s), 16'h30);
      wait_digit(2, s); chk("1a3f_d2", 16'(s), 16'h08);
      wait_digit(3, s); chk("1a3f_d3", 16'(s), 16'h79);
      wait_digit(0, s); chk("2222_d0", 16'(s), 16'h24);

      // Leading-zero blanking
      show("blank5", 16'h0005, 1'b1, 7'h12, 7'h7F, 7'h7F, 7'h7F);
      show("noblank5", 16'h0005, 1'b0, 7'h12, 7'h40, 7'h40, 7'h40);
      show("blank500", 16'h0500, 1'b1, 7'h40, 7'h40, 7'h12, 7'h7F);

      // Transfer in the frame-end cycle waits a whole extra frame
      wait_pos(FRAME, FRAME - 1, 60);
      load_valid = 1'b1; load_data = 16'h0009; load_blank = 1'b0;
      @(negedge clk);
      load_valid = 1'b0;
      chk("fe_ready_low", 16'(load_ready), 16'd0);
      tick(1);
      wait_digit(0, s); chk("fe_old_d0", 16'(s), 16'h40);
      tick(8);
      wait_digit(0, s); chk("fe_new_d0", 16'(s), 16'h10);

      // Reset with a pending entry while digit 2 is scanning
      wait_pos(FRAME, 1, 60);
      load_valid = 1'b1; load_data = 16'h4321; load_blank = 1'b0;
      @(negedge clk);
      load_valid = 1'b0;
      n = 0;
      while (((m_t / DIV) % 4) != 2 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("mid_pending", 16'(load_ready), 16'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_ready", 16'(load_ready), 16'd1);
      chk("mid_dig", 16'(dig_en_n), 16'hF);
      chk("mid_seg", 16'(seg_n), 16'h7F);
      tick(1);
      chk("mid_guard", 16'(dig_en_n), 16'hF);
      tick(1);
      chk("mid_restart_dig", 16'(dig_en_n), 16'hE);
      chk("mid_restart_seg", 16'(seg_n), 16'h40);
      tick(20);
      wait_digit(0, s); chk("mid_discard_d0", 16'(s), 16'h40);
      wait_digit(1, s); chk("mid_discard_d1", 16'(s), 16'h7F);

      // Reset wins over a simultaneous transfer
      rst = 1'b1; load_valid = 1'b1; load_data = 16'h8888; load_blank = 1'b0;
      @(negedge clk);
      rst = 1'b0; load_valid = 1'b0;
      chk("rst_prio_ready", 16'(load_ready), 16'd1);

      // Random sweep; the compare process checks every cycle
      repeat (64) begin
         load_valid = 1'($urandom_range(0, 1));
         load_data  = 16'($urandom);
         load_blank = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      load_valid = 1'b0;
      tick(40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
